// File: rtl/tlb_pkg.sv
// Shared TLB types and constants for the TLB op sequencer and its helpers.
package tlb_pkg;

  localparam int unsigned TLB_ENTRIES = 8;
  localparam int unsigned TLB_IDX_W   = $clog2(TLB_ENTRIES);
  localparam int unsigned TLB_CONF_W  = 86;
  localparam int unsigned INDEX_W     = 32;
  localparam int unsigned INDEX_P_BIT = 31;

  // TLB instruction encoding as presented by the execute stage.
  typedef enum logic [1:0] {
    TLBP  = 2'd0,
    TLBR  = 2'd1,
    TLBWI = 2'd2,
    TLBWR = 2'd3
  } tlb_op_e;

  // Sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_WRITE        = 3'd1,
    ST_PROBE_SETTLE = 3'd2,
    ST_PROBE_CAP    = 3'd3,
    ST_READ         = 3'd4,
    ST_REFETCH      = 3'd5
  } tlb_state_e;

endpackage

// File: rtl/tlb_random_ctr.sv
// CP0 Random: free-running down-counter bounded below by Wired, frozen while
// a TLBWR strobe uses it as the write target.
module tlb_random_ctr
  import tlb_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES = TLB_ENTRIES,
  parameter int unsigned IDX_W       = $clog2(NUM_ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] wired_i,
  input  logic             wired_we_i,
  input  logic             freeze_i,
  output logic [IDX_W-1:0] random_o
);

  localparam logic [IDX_W-1:0] TOP = IDX_W'(NUM_ENTRIES - 1);

  logic [IDX_W-1:0] random_q, random_d;

  // Next value: Wired write restarts at top, freeze holds, otherwise count down and wrap at Wired.
  always_comb begin
    random_d = random_q;
    if (wired_we_i) begin
      random_d = TOP;
    end else if (freeze_i) begin
      random_d = random_q;
    end else if (random_q <= wired_i) begin
      random_d = TOP;
    end else begin
      random_d = random_q - IDX_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      random_q <= TOP;
    end else begin
      random_q <= random_d;
    end
  end

  assign random_o = random_q;

endmodule

// File: rtl/tlb_op_sequencer.sv
// Sequences TLBP/TLBR/TLBWI/TLBWR from EX onto the shared TLB array: stalls
// the pipeline, issues one-cycle strobes, captures probe results into CP0
// Index and requests a refetch after any TLB write.
module tlb_op_sequencer
  import tlb_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES = TLB_ENTRIES,
  parameter int unsigned IDX_W       = $clog2(NUM_ENTRIES)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               op_valid_i,
  input  logic [1:0]         op_type_i,
  input  logic               op_kill_i,
  output logic               op_stall_o,
  output logic               op_done_o,
  output logic               tlbwi_o,
  output logic               tlbwr_o,
  output logic               tlbp_o,
  input  logic               miss_probe_i,
  input  logic [IDX_W-1:0]   matched_index_probe_i,
  output logic               cp0_index_we_o,
  output logic [INDEX_W-1:0] cp0_index_wdata_o,
  output logic               cp0_tlbr_we_o,
  input  logic [IDX_W-1:0]   cp0_wired_i,
  input  logic               cp0_wired_we_i,
  output logic [IDX_W-1:0]   cp0_random_o,
  output logic               refetch_req_o
);

  tlb_state_e state_q, state_d;
  tlb_op_e    op_q, op_d;

  // State and accepted-op registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= TLBP;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  // Next-state and output decode; writes are not killable once issued.
  always_comb begin
    state_d           = state_q;
    op_d              = op_q;
    op_stall_o        = 1'b0;
    op_done_o         = 1'b0;
    tlbwi_o           = 1'b0;
    tlbwr_o           = 1'b0;
    tlbp_o            = 1'b0;
    cp0_index_we_o    = 1'b0;
    cp0_index_wdata_o = '0;
    cp0_tlbr_we_o     = 1'b0;
    refetch_req_o     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (op_valid_i && !op_kill_i) begin
          op_stall_o = 1'b1;
          op_d       = tlb_op_e'(op_type_i);
          unique case (tlb_op_e'(op_type_i))
            TLBP:    state_d = ST_PROBE_SETTLE;
            TLBR:    state_d = ST_READ;
            default: state_d = ST_WRITE;
          endcase
        end
      end

      ST_WRITE: begin
        op_stall_o = 1'b1;
        tlbwi_o    = (op_q == TLBWI);
        tlbwr_o    = (op_q == TLBWR);
        state_d    = ST_REFETCH;
      end

      ST_REFETCH: begin
        refetch_req_o = 1'b1;
        op_done_o     = 1'b1;
        state_d       = ST_IDLE;
      end

      ST_PROBE_SETTLE: begin
        op_stall_o = 1'b1;
        if (op_kill_i) begin
          state_d = ST_IDLE;
        end else begin
          tlbp_o  = 1'b1;
          state_d = ST_PROBE_CAP;
        end
      end

      ST_PROBE_CAP: begin
        state_d = ST_IDLE;
        if (op_kill_i) begin
          op_stall_o = 1'b1;
        end else begin
          tlbp_o         = 1'b1;
          cp0_index_we_o = 1'b1;
          op_done_o      = 1'b1;
          if (miss_probe_i) begin
            cp0_index_wdata_o[INDEX_P_BIT] = 1'b1;
          end else begin
            cp0_index_wdata_o = INDEX_W'(matched_index_probe_i);
          end
        end
      end

      ST_READ: begin
        state_d = ST_IDLE;
        if (op_kill_i) begin
          op_stall_o = 1'b1;
        end else begin
          cp0_tlbr_we_o = 1'b1;
          op_done_o     = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Random counter; frozen while its value is the TLBWR target.
  tlb_random_ctr #(
    .NUM_ENTRIES (NUM_ENTRIES),
    .IDX_W       (IDX_W)
  ) u_random (
    .clk        (clk),
    .rst        (rst),
    .wired_i    (cp0_wired_i),
    .wired_we_i (cp0_wired_we_i),
    .freeze_i   (tlbwr_o),
    .random_o   (cp0_random_o)
  );

endmodule

// File: tb/tb_tlb_op_sequencer.sv
// Directed bench for tlb_op_sequencer with hand-computed expectations.
module tb_tlb_op_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid, op_kill;
  logic [1:0]  op_type;
  logic        op_stall, op_done, tlbwi, tlbwr, tlbp;
  logic        miss_probe;
  logic [2:0]  matched_index_probe;
  logic        cp0_index_we, cp0_tlbr_we, refetch_req;
  logic [31:0] cp0_index_wdata;
  logic [2:0]  cp0_wired, cp0_random;
  logic        cp0_wired_we;

  int total = 0;
  int bad   = 0;
  bit entry_written = 1'b0;

  always #5 clk = ~clk;

  tlb_op_sequencer dut (
    .clk                   (clk),
    .rst                   (rst),
    .op_valid_i            (op_valid),
    .op_type_i             (op_type),
    .op_kill_i             (op_kill),
    .op_stall_o            (op_stall),
    .op_done_o             (op_done),
    .tlbwi_o               (tlbwi),
    .tlbwr_o               (tlbwr),
    .tlbp_o                (tlbp),
    .miss_probe_i          (miss_probe),
    .matched_index_probe_i (matched_index_probe),
    .cp0_index_we_o        (cp0_index_we),
    .cp0_index_wdata_o     (cp0_index_wdata),
    .cp0_tlbr_we_o         (cp0_tlbr_we),
    .cp0_wired_i           (cp0_wired),
    .cp0_wired_we_i        (cp0_wired_we),
    .cp0_random_o          (cp0_random),
    .refetch_req_o         (refetch_req)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle before sampling.
  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1; op_valid = 1'b0; op_kill = 1'b0; op_type = 2'd0;
    miss_probe = 1'b1; matched_index_probe = 3'd0;
    cp0_wired = 3'd7; cp0_wired_we = 1'b0;
    tick(); tick();
    rst = 1'b0;
    settle();
    check_eq("rst_random", 32'(cp0_random), 32'd7);
    check_eq("rst_stall", 32'(op_stall), 32'd0);
    check_eq("rst_strobes", 32'({tlbwi, tlbwr, tlbp, cp0_index_we, cp0_tlbr_we, op_done, refetch_req}), 32'd0);
    check_eq("rst_wdata", cp0_index_wdata, 32'd0);

    // Reset pulsed in PROBE_SETTLE.
    tick(); op_valid = 1'b1; op_type = 2'd0; settle();
    check_eq("rstmid_accept_stall", 32'(op_stall), 32'd1);
    tick(); op_valid = 1'b0; settle();
    check_eq("rstmid_settle_tlbp", 32'(tlbp), 32'd1);
    rst = 1'b1; settle();
    check_eq("rstmid_async_tlbp", 32'(tlbp), 32'd0);
    check_eq("rstmid_async_stall", 32'(op_stall), 32'd0);
    tick(); rst = 1'b0; settle();
    check_eq("rstmid_random", 32'(cp0_random), 32'd7);
    check_eq("rstmid_idle", 32'({tlbp, cp0_index_we, op_done, op_stall}), 32'd0);
    tick(); settle();
    check_eq("rstmid_no_cap", 32'({tlbp, cp0_index_we, op_done}), 32'd0);

    // TLBWI latency and strobes.
    tick(); op_valid = 1'b1; op_type = 2'd2; settle();
    check_eq("wi_T_stall", 32'(op_stall), 32'd1);
    check_eq("wi_T_strobe", 32'({tlbwi, tlbwr}), 32'd0);
    tick(); op_valid = 1'b0; settle();
    check_eq("wi_T1_strobes", 32'({tlbwi, tlbwr}), 32'b10);
    check_eq("wi_T1_stall", 32'(op_stall), 32'd1);
    check_eq("wi_T1_done", 32'({op_done, refetch_req}), 32'd0);
    tick(); settle();
    check_eq("wi_T2_done_refetch", 32'({op_done, refetch_req}), 32'b11);
    check_eq("wi_T2_stall", 32'(op_stall), 32'd0);
    check_eq("wi_T2_strobes", 32'({tlbwi, tlbwr}), 32'd0);
    check_eq("wi_random_held", 32'(cp0_random), 32'd7);
    tick(); settle();
    check_eq("wi_T3_quiet", 32'({op_done, refetch_req, op_stall}), 32'd0);

    // TLBP hit.
    tick(); op_valid = 1'b1; op_type = 2'd0; settle();
    tick(); op_valid = 1'b0; settle();
    check_eq("ph_settle", 32'({tlbp, cp0_index_we, op_done, op_stall}), 32'b1001);
    tick(); miss_probe = 1'b0; matched_index_probe = 3'd5; settle();
    check_eq("ph_cap_ctl", 32'({tlbp, cp0_index_we, op_done, op_stall}), 32'b1110);
    check_eq("ph_wdata", cp0_index_wdata, 32'h0000_0005);

    // TLBP miss.
    tick(); op_valid = 1'b1; op_type = 2'd0; miss_probe = 1'b1; matched_index_probe = 3'd0; settle();
    tick(); op_valid = 1'b0; settle();
    tick(); settle();
    check_eq("pm_we", 32'(cp0_index_we), 32'd1);
    check_eq("pm_wdata", cp0_index_wdata, 32'h8000_0000);

    // TLBR.
    tick(); op_valid = 1'b1; op_type = 2'd1; settle();
    check_eq("r_T_tlbr_we", 32'(cp0_tlbr_we), 32'd0);
    tick(); op_valid = 1'b0; settle();
    check_eq("r_T1", 32'({cp0_tlbr_we, op_done, op_stall}), 32'b110);

    // Random sequence with Wired=3.
    tick(); cp0_wired = 3'd3; cp0_wired_we = 1'b1; settle();
    begin
      logic [2:0] seq [7] = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd7, 3'd6};
      for (int i = 0; i < 7; i++) begin
        tick(); cp0_wired_we = 1'b0; settle();
        check_eq($sformatf("rnd_seq%0d", i), 32'(cp0_random), 32'(seq[i]));
      end
    end
    tick(); cp0_wired_we = 1'b1; settle();
    check_eq("rnd_before_we", 32'(cp0_random), 32'd5);
    tick(); cp0_wired_we = 1'b0; settle();
    check_eq("rnd_after_we", 32'(cp0_random), 32'd7);
    tick(); op_valid = 1'b1; op_type = 2'd3; settle();
    check_eq("wr_T_random", 32'(cp0_random), 32'd6);
    tick(); op_valid = 1'b0; settle();
    check_eq("wr_T1_strobes", 32'({tlbwi, tlbwr}), 32'b01);
    check_eq("wr_T1_target", 32'(cp0_random), 32'd5);
    tick(); settle();
    check_eq("wr_T2_frozen", 32'(cp0_random), 32'd5);
    check_eq("wr_T2_refetch", 32'({op_done, refetch_req}), 32'b11);
    tick(); settle();
    check_eq("wr_T3_resume", 32'(cp0_random), 32'd4);
    cp0_wired = 3'd7; cp0_wired_we = 1'b1;
    tick(); cp0_wired_we = 1'b0; settle();
    check_eq("rnd_restore", 32'(cp0_random), 32'd7);

    // Kill in PROBE_SETTLE.
    tick(); op_valid = 1'b1; op_type = 2'd0; settle();
    tick(); op_valid = 1'b0; op_kill = 1'b1; settle();
    check_eq("kp_T1", 32'({cp0_index_we, op_done, tlbp}), 32'd0);
    tick(); op_kill = 1'b0; settle();
    check_eq("kp_T2", 32'({cp0_index_we, op_done, tlbp, op_stall}), 32'd0);

    // Kill in WRITE is ignored.
    tick(); op_valid = 1'b1; op_type = 2'd2; settle();
    tick(); op_valid = 1'b0; op_kill = 1'b1; settle();
    check_eq("kw_T1_strobe", 32'(tlbwi), 32'd1);
    tick(); settle();
    check_eq("kw_T2_refetch", 32'({op_done, refetch_req}), 32'b11);

    // Kill together with op_valid in IDLE: not accepted.
    tick(); op_valid = 1'b1; op_type = 2'd2; op_kill = 1'b1; settle();
    check_eq("ki_stall", 32'(op_stall), 32'd0);
    tick(); op_valid = 1'b0; op_kill = 1'b0; settle();
    check_eq("ki_no_strobe", 32'({tlbwi, op_stall}), 32'd0);

    // Back-to-back TLBWI then TLBP; the probe answers from the written entry.
    tick(); op_valid = 1'b1; op_type = 2'd2; settle();
    tick(); settle();
    if (tlbwi) entry_written = 1'b1;
    check_eq("bb_write", 32'(tlbwi), 32'd1);
    tick(); op_type = 2'd0; settle();
    check_eq("bb_done1", 32'(op_done), 32'd1);
    check_eq("bb_tlbp_not_yet", 32'({op_stall, tlbp}), 32'd0);
    tick(); settle();
    check_eq("bb_accept2", 32'(op_stall), 32'd1);
    tick(); op_valid = 1'b0; settle();
    check_eq("bb_settle", 32'(tlbp), 32'd1);
    tick(); miss_probe = !entry_written; matched_index_probe = 3'd2; settle();
    check_eq("bb_cap_we", 32'({cp0_index_we, op_done}), 32'b11);
    check_eq("bb_cap_wdata", cp0_index_wdata, 32'h0000_0002);

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
